// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 8-digit display path: digit geometry, the
// button-loader FSM state encoding and a pointer wrap helper.
// -----------------------------------------------------------------------------
package seg_pkg;

   // Display geometry shared with the display register file
   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned ADDR_W     = 3;
   localparam int unsigned DATA_W     = 4;

   // Button loader FSM states
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRESS_DB = 3'd1,
      FIRE     = 3'd2,
      HELD     = 3'd3,
      REL_DB   = 3'd4
   } loader_state_e;

   // Advance a digit pointer, wrapping from the last digit back to 0
   function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
      if (p == ADDR_W'(NUM_DIGITS - 1)) begin
         return '0;
      end
      return p + ADDR_W'(1);
   endfunction

endpackage : seg_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a group of asynchronous inputs. Each bit is
// synchronized independently; the group is not guaranteed to be coherent.
//
// Ports
//   clk    : system clock
//   reset  : synchronous, active-high reset (both stages cleared)
//   d_i    : asynchronous input bits
//   q_o    : synchronized output bits (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Metastability stage followed by the stable output stage
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/btn_digit_loader.sv
// -----------------------------------------------------------------------------
// btn_digit_loader
// Debounces a write push-button and, once per accepted press, issues a
// single-cycle write of a switch-selected digit value into the 8-digit
// display register file. The digit index comes either from the slide
// switches or from an internal auto-incrementing pointer.
//
// Ports
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high reset
//   btn_raw   : asynchronous, bouncing push-button (1 = pressed)
//   sw_num    : asynchronous digit value switches
//   sw_sel    : asynchronous digit index switches
//   auto_inc  : asynchronous mode switch (1 = use internal pointer)
//   ptr_clr   : synchronous pulse, clears the internal pointer
//   wr_en     : single-cycle write strobe
//   wr_addr   : digit index qualified by wr_en
//   wr_data   : digit value qualified by wr_en
//   ptr       : current auto-increment pointer
//   busy      : FSM is not idle
// -----------------------------------------------------------------------------
module btn_digit_loader
   import seg_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_raw,
   input  logic [DATA_W-1:0] sw_num,
   input  logic [ADDR_W-1:0] sw_sel,
   input  logic              auto_inc,
   input  logic              ptr_clr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W-1:0] ptr,
   output logic              busy
);

   localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // ---------------------------------------------------------------------
   // Input synchronization, one synchronizer per input group
   // ---------------------------------------------------------------------
   logic              btn_s;
   logic [DATA_W-1:0] num_s;
   logic [ADDR_W-1:0] sel_s;
   logic              auto_s;

   sync_2ff #(.WIDTH(1)) u_sync_btn (
      .clk   (clk),
      .reset (reset),
      .d_i   (btn_raw),
      .q_o   (btn_s)
   );

   sync_2ff #(.WIDTH(DATA_W)) u_sync_num (
      .clk   (clk),
      .reset (reset),
      .d_i   (sw_num),
      .q_o   (num_s)
   );

   sync_2ff #(.WIDTH(ADDR_W)) u_sync_sel (
      .clk   (clk),
      .reset (reset),
      .d_i   (sw_sel),
      .q_o   (sel_s)
   );

   sync_2ff #(.WIDTH(1)) u_sync_auto (
      .clk   (clk),
      .reset (reset),
      .d_i   (auto_inc),
      .q_o   (auto_s)
   );

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   loader_state_e     state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic [ADDR_W-1:0] ptr_q;
   logic              busy_q;
   // Mode captured with the write, so the pointer only moves for auto writes
   logic              fire_auto_q;

   // Next-state and debounce counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (btn_s) state_d = PRESS_DB;
         end
         PRESS_DB: begin
            if (!btn_s)                state_d = IDLE;
            else if (cnt_q == CNT_MAX) state_d = FIRE;
            else                       cnt_d   = cnt_q + CNT_W'(1);
         end
         FIRE: begin
            state_d = HELD;
         end
         HELD: begin
            if (!btn_s) state_d = REL_DB;
         end
         REL_DB: begin
            if (btn_s)                 state_d = HELD;
            else if (cnt_q == CNT_MAX) state_d = IDLE;
            else                       cnt_d   = cnt_q + CNT_W'(1);
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Every state change restarts the debounce window
      if (state_d != state_q) cnt_d = '0;
   end

   // FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         ptr_q       <= '0;
         busy_q      <= 1'b0;
         fire_auto_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_en_q <= (state_d == FIRE);
         busy_q  <= (state_d != IDLE);

         // Capture the write payload on entry to FIRE; held until the next one
         if (state_d == FIRE && state_q != FIRE) begin
            wr_data_q   <= num_s;
            wr_addr_q   <= auto_s ? ptr_q : sel_s;
            fire_auto_q <= auto_s;
         end

         // Clear wins over the post-write increment
         if (ptr_clr) begin
            ptr_q <= '0;
         end else if (state_q == FIRE && fire_auto_q) begin
            ptr_q <= ptr_next(ptr_q);
         end
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign ptr     = ptr_q;
   assign busy    = busy_q;

endmodule : btn_digit_loader

// File: tb/tb_btn_digit_loader.sv
// -----------------------------------------------------------------------------
// tb_btn_digit_loader
// Scoreboard bench for btn_digit_loader with DEBOUNCE_CYCLES = 4.
// The reference model views the button as a run-length filter: a new level
// is accepted after DB+1 consecutive synchronized samples that differ from
// the accepted level, and the edge right after a 0->1 acceptance is ignored.
// -----------------------------------------------------------------------------
module tb_btn_digit_loader;

   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_raw;
   logic [3:0] sw_num;
   logic [2:0] sw_sel;
   logic       auto_inc;
   logic       ptr_clr;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [3:0] wr_data;
   logic [2:0] ptr;
   logic       busy;

   btn_digit_loader #(.DEBOUNCE_CYCLES(DB)) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_raw  (btn_raw),
      .sw_num   (sw_num),
      .sw_sel   (sw_sel),
      .auto_inc (auto_inc),
      .ptr_clr  (ptr_clr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .ptr      (ptr),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } exp_t;

   exp_t exp_q[$];

   int  errors = 0;
   int  checks = 0;
   bit  chk_en = 0;
   bit  stim_done = 0;

   // Reference model state
   int  m_level, m_run, m_in_fire, m_fire_auto, m_ptr;
   int  m_b1, m_b2, m_n1, m_n2, m_s1, m_s2, m_a1, m_a2;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc_cnt);
      end
   endtask

   task automatic model_clear();
      m_level = 0; m_run = 0; m_in_fire = 0; m_fire_auto = 0; m_ptr = 0;
      m_b1 = 0; m_b2 = 0; m_n1 = 0; m_n2 = 0; m_s1 = 0; m_s2 = 0; m_a1 = 0; m_a2 = 0;
   endtask

   // Model one rising edge with the given input values
   task automatic model_step(input int b, input int n, input int s, input int a,
                             input int c, input int r);
      int   old_ptr;
      exp_t e;
      if (r != 0) begin
         model_clear();
         return;
      end
      old_ptr = m_ptr;
      if (c != 0)                              m_ptr = 0;
      else if (m_in_fire != 0 && m_fire_auto != 0) m_ptr = (m_ptr + 1) % 8;

      if (m_in_fire != 0) begin
         m_in_fire = 0;
         m_run     = 0;
      end else if (m_b2 != m_level) begin
         m_run++;
         if (m_run == DB + 1) begin
            m_level = m_b2;
            m_run   = 0;
            if (m_level == 1) begin
               m_in_fire   = 1;
               m_fire_auto = m_a2;
               e.addr = (m_a2 != 0) ? old_ptr : m_s2;
               e.data = m_n2;
               e.cyc  = cyc_cnt + 1;
               exp_q.push_back(e);
            end
         end
      end else begin
         m_run = 0;
      end

      m_b2 = m_b1; m_b1 = b;
      m_n2 = m_n1; m_n1 = n;
      m_s2 = m_s1; m_s1 = s;
      m_a2 = m_a1; m_a1 = a;
   endtask

   // One cycle: check state-level outputs, drive inputs, advance the model
   task automatic tick(input logic b, input logic [3:0] n, input logic [2:0] s,
                       input logic a, input logic c, input logic r);
      @(negedge clk);
      if (chk_en) begin
         check("ptr",  int'(ptr),  m_ptr);
         check("busy", int'(busy), (m_level != 0 || m_run != 0) ? 1 : 0);
      end
      btn_raw  = b;
      sw_num   = n;
      sw_sel   = s;
      auto_inc = a;
      ptr_clr  = c;
      reset    = r;
      model_step(int'(b), int'(n), int'(s), int'(a), int'(c), int'(r));
      if (r) chk_en = 1;
   endtask

   // Hold the button, optionally clearing the pointer during the FIRE cycle
   task automatic press(input logic [3:0] n, input logic [2:0] s, input logic a,
                        input int hold, input int rel, input bit clr_in_fire);
      for (int i = 0; i < hold; i++)
         tick(1'b1, n, s, a, (clr_in_fire && m_in_fire != 0), 1'b0);
      for (int i = 0; i < rel; i++)
         tick(1'b0, n, s, a, 1'b0, 1'b0);
   endtask

   initial begin
      model_clear();
      btn_raw = 0; sw_num = 0; sw_sel = 0; auto_inc = 0; ptr_clr = 0; reset = 1;

      fork
         // ---------------- stimulus ----------------
         begin
            for (int i = 0; i < 3; i++) tick(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            check("reset_wr_en",   int'(wr_en),   0);
            check("reset_wr_addr", int'(wr_addr), 0);
            check("reset_wr_data", int'(wr_data), 0);
            check("reset_ptr",     int'(ptr),     0);
            check("reset_busy",    int'(busy),    0);

            // Clean press
            press(4'd9, 3'd5, 1'b0, 20, 10, 1'b0);

            // Bounce, then stable
            for (int k = 0; k < 2; k++) begin
               tick(1'b1, 4'd3, 3'd2, 1'b0, 1'b0, 1'b0);
               tick(1'b1, 4'd3, 3'd2, 1'b0, 1'b0, 1'b0);
               tick(1'b0, 4'd3, 3'd2, 1'b0, 1'b0, 1'b0);
               tick(1'b0, 4'd3, 3'd2, 1'b0, 1'b0, 1'b0);
            end
            press(4'd3, 3'd2, 1'b0, 15, 10, 1'b0);

            // Auto-increment across the wrap
            for (int k = 0; k < 9; k++) press(4'(k), 3'd6, 1'b1, 10, 10, 1'b0);
            check("auto_ptr_end", int'(ptr), 1);

            // Clear colliding with the post-write increment
            tick(1'b0, 4'd0, 3'd0, 1'b1, 1'b1, 1'b0);
            for (int k = 0; k < 3; k++) press(4'd1, 3'd0, 1'b1, 10, 10, 1'b0);
            check("ptr_before_clr", int'(ptr), 3);
            press(4'd7, 3'd0, 1'b1, 10, 10, 1'b1);
            check("ptr_after_clr", int'(ptr), 0);
            check("clr_write_addr", int'(wr_addr), 3);

            // Release glitch while held
            for (int i = 0; i < 10; i++) tick(1'b1, 4'd4, 3'd1, 1'b0, 1'b0, 1'b0);
            tick(1'b0, 4'd4, 3'd1, 1'b0, 1'b0, 1'b0);
            tick(1'b0, 4'd4, 3'd1, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 6; i++) tick(1'b1, 4'd4, 3'd1, 1'b0, 1'b0, 1'b0);
            check("glitch_busy", int'(busy), 1);
            for (int i = 0; i < 10; i++) tick(1'b0, 4'd4, 3'd1, 1'b0, 1'b0, 1'b0);

            // Reset mid-debounce with the button held
            for (int i = 0; i < 4; i++) tick(1'b1, 4'd8, 3'd7, 1'b0, 1'b0, 1'b0);
            tick(1'b1, 4'd8, 3'd7, 1'b0, 1'b0, 1'b1);
            tick(1'b1, 4'd8, 3'd7, 1'b0, 1'b0, 1'b1);
            check("rst_mid_wr_en", int'(wr_en), 0);
            check("rst_mid_busy",  int'(busy),  0);
            press(4'd8, 3'd7, 1'b0, 12, 10, 1'b0);

            // Randomized segments
            begin
               logic lvl;
               logic [3:0] n;
               logic [2:0] s;
               logic a;
               lvl = 1'b0;
               for (int seg = 0; seg < 250; seg++) begin
                  int len;
                  lvl = ~lvl;
                  len = $urandom_range(1, 12);
                  n = 4'($urandom_range(0, 15));
                  s = 3'($urandom_range(0, 7));
                  a = 1'($urandom_range(0, 1));
                  for (int i = 0; i < len; i++)
                     tick(lvl, n, s, a, ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 199) == 0));
               end
            end

            for (int i = 0; i < 20; i++) tick(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
            check("queue_drained", exp_q.size(), 0);
            stim_done = 1;
         end

         // ---------------- write monitor ----------------
         begin
            while (!stim_done) begin
               @(negedge clk);
               if (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
                  check("missing_wr_en", 0, 1);
                  void'(exp_q.pop_front());
               end
               if (wr_en === 1'b1) begin
                  if (exp_q.size() == 0) begin
                     check("unexpected_wr_en", 1, 0);
                  end else begin
                     exp_t e;
                     e = exp_q.pop_front();
                     check("wr_cycle", cyc_cnt, e.cyc);
                     check("wr_addr", int'(wr_addr), e.addr);
                     check("wr_data", int'(wr_data), e.data);
                  end
               end
            end
         end
      join

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_btn_digit_loader
